// File: rtl/spaced_bitmap_dec_if.sv
// Request/response bundle between the index producers and the bitmap decoder.
interface spaced_bitmap_dec_if #(
   parameter int INPUT_WIDTH  = 8192,
   parameter int PENC1_SIZE   = 32,
   parameter int PENC2_SIZE   = 32,
   parameter int BIN_COUNT    = 8,
   parameter int LARGE_BLOCK  = BIN_COUNT * PENC1_SIZE * PENC2_SIZE,
   parameter int OUTPUT_WIDTH = $clog2(LARGE_BLOCK),
   parameter int CNT_WIDTH    = $clog2(LARGE_BLOCK / BIN_COUNT) + 1
);
   logic [BIN_COUNT*OUTPUT_WIDTH-1:0] set_index;
   logic [BIN_COUNT-1:0]              set_valid;
   logic [BIN_COUNT-1:0]              set_ready;
   logic [OUTPUT_WIDTH-1:0]           clr_index;
   logic                              clr_valid;
   logic                              clr_ready;
   logic [INPUT_WIDTH-1:0]            one_hot;
   logic [BIN_COUNT*CNT_WIDTH-1:0]    bin_count;
   logic [BIN_COUNT-1:0]              set_error;
   logic                              clr_error;

   modport master (
      output set_index, set_valid, clr_index, clr_valid,
      input  set_ready, clr_ready, one_hot, bin_count, set_error, clr_error
   );

   modport slave (
      input  set_index, set_valid, clr_index, clr_valid,
      output set_ready, clr_ready, one_hot, bin_count, set_error, clr_error
   );
endinterface

// File: rtl/spaced_bitmap_dec.sv
// Index-to-bitmap decoder: per-bin set streams and one shared clear stream
// maintain a registered occupancy bitmap plus per-bin population counters.
module spaced_bitmap_dec #(
   parameter int INPUT_WIDTH  = 8192,
   parameter int PENC1_SIZE   = 32,
   parameter int PENC2_SIZE   = 32,
   parameter int BIN_COUNT    = 8,
   parameter int LARGE_BLOCK  = BIN_COUNT * PENC1_SIZE * PENC2_SIZE,
   parameter int OUTPUT_WIDTH = $clog2(LARGE_BLOCK),
   parameter int CNT_WIDTH    = $clog2(LARGE_BLOCK / BIN_COUNT) + 1
) (
   input  logic              clk,
   input  logic              rst,
   spaced_bitmap_dec_if.slave bus
);
   localparam int BIN_W = $clog2(BIN_COUNT);

   typedef enum logic {INIT, RUN} state_t;

   state_t                  state_q;
   logic [INPUT_WIDTH-1:0]  one_hot_q, one_hot_d;
   logic [CNT_WIDTH-1:0]    cnt_q [BIN_COUNT];
   logic [CNT_WIDTH-1:0]    cnt_d [BIN_COUNT];
   logic [BIN_COUNT-1:0]    set_err_q, set_err_d;
   logic                    clr_err_q, clr_err_d;

   logic                    ready;
   logic [OUTPUT_WIDTH-1:0] set_idx [BIN_COUNT];
   logic [INPUT_WIDTH-1:0]  clr_mask, set_mask, after_clr;
   logic [BIN_COUNT-1:0]    set_ok;
   logic                    clr_ok;

   // No backpressure once running; ready depends on state alone.
   assign ready = (state_q == RUN);

   // Decode requests; the clear is applied before the set checks so that a
   // same-cycle clear+set of one index is legal and leaves the bit at 1.
   always_comb begin
      clr_mask  = '0;
      set_mask  = '0;
      set_ok    = '0;
      set_err_d = '0;
      clr_ok    = 1'b0;
      clr_err_d = 1'b0;
      for (int b = 0; b < BIN_COUNT; b++) begin
         set_idx[b] = bus.set_index[b*OUTPUT_WIDTH +: OUTPUT_WIDTH];
      end
      if (ready && bus.clr_valid) begin
         if ((int'(bus.clr_index) < INPUT_WIDTH) && one_hot_q[bus.clr_index]) begin
            clr_ok                  = 1'b1;
            clr_mask[bus.clr_index] = 1'b1;
         end else begin
            clr_err_d = 1'b1;
         end
      end
      after_clr = one_hot_q & ~clr_mask;
      for (int b = 0; b < BIN_COUNT; b++) begin
         if (ready && bus.set_valid[b]) begin
            if ((set_idx[b][BIN_W-1:0] == BIN_W'(b)) &&
                (int'(set_idx[b]) < INPUT_WIDTH) && !after_clr[set_idx[b]]) begin
               set_ok[b]            = 1'b1;
               set_mask[set_idx[b]] = 1'b1;
            end else begin
               set_err_d[b] = 1'b1;
            end
         end
      end
      one_hot_d = after_clr | set_mask;
      for (int b = 0; b < BIN_COUNT; b++) begin
         cnt_d[b] = cnt_q[b] + CNT_WIDTH'(set_ok[b])
                  - CNT_WIDTH'(clr_ok && (bus.clr_index[BIN_W-1:0] == BIN_W'(b)));
      end
   end

   // State, bitmap, counters and error pulses; reset drops any request.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= INIT;
         one_hot_q <= '0;
         set_err_q <= '0;
         clr_err_q <= 1'b0;
         for (int b = 0; b < BIN_COUNT; b++) cnt_q[b] <= '0;
      end else begin
         state_q   <= RUN;
         one_hot_q <= one_hot_d;
         set_err_q <= set_err_d;
         clr_err_q <= clr_err_d;
         for (int b = 0; b < BIN_COUNT; b++) cnt_q[b] <= cnt_d[b];
      end
   end

   // Flatten the counter array onto the output bus.
   always_comb begin
      bus.bin_count = '0;
      for (int b = 0; b < BIN_COUNT; b++) begin
         bus.bin_count[b*CNT_WIDTH +: CNT_WIDTH] = cnt_q[b];
      end
   end

   assign bus.set_ready = {BIN_COUNT{ready}};
   assign bus.clr_ready = ready;
   assign bus.one_hot   = one_hot_q;
   assign bus.set_error = set_err_q;
   assign bus.clr_error = clr_err_q;
endmodule

// File: tb/tb_spaced_bitmap_dec.sv
// Scoreboard bench for spaced_bitmap_dec: a behavioural model predicts each
// cycle's outcome when stimulus is driven; results are compared after the edge.
module tb_spaced_bitmap_dec;
   localparam int IW = 8192;
   localparam int BC = 8;
   localparam int OW = 13;
   localparam int CW = 11;

   typedef struct {
      logic [IW-1:0] oh;
      logic [127:0]  cnt;
      logic [BC-1:0] serr;
      logic          cerr;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_fail   = 0;

   exp_t          sb_q[$];
   logic [IW-1:0] om;
   int            cm [BC];
   logic          state_m;

   spaced_bitmap_dec_if bus ();

   spaced_bitmap_dec dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog obs=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] fold(input logic [IW-1:0] v);
      logic [63:0] h = '0;
      for (int i = 0; i < IW/64; i++) h = {h[62:0], h[63]} ^ v[i*64 +: 64];
      return h;
   endfunction

   task automatic idle();
      bus.set_valid = '0;
      bus.set_index = '0;
      bus.clr_valid = 1'b0;
      bus.clr_index = '0;
   endtask

   task automatic set_req(input int b, input int idx);
      bus.set_valid[b]            = 1'b1;
      bus.set_index[b*OW +: OW]   = OW'(idx);
   endtask

   task automatic clr_req(input int idx);
      bus.clr_valid = 1'b1;
      bus.clr_index = OW'(idx);
   endtask

   // One clock: predict, push, clock, pop and compare.
   task automatic step();
      exp_t e;
      exp_t g;
      int   idx;
      chk("set_ready", 128'(bus.set_ready), 128'({BC{state_m}}));
      chk("clr_ready", 128'(bus.clr_ready), 128'(state_m));
      e.serr = '0;
      e.cerr = 1'b0;
      if (rst) begin
         om = '0;
         for (int b = 0; b < BC; b++) cm[b] = 0;
      end else if (state_m) begin
         if (bus.clr_valid) begin
            idx = int'(bus.clr_index);
            if (idx < IW && om[idx]) begin
               om[idx] = 1'b0;
               cm[idx % BC]--;
            end else e.cerr = 1'b1;
         end
         for (int b = 0; b < BC; b++) begin
            if (bus.set_valid[b]) begin
               idx = int'(bus.set_index[b*OW +: OW]);
               if ((idx % BC) == b && idx < IW && !om[idx]) begin
                  om[idx] = 1'b1;
                  cm[b]++;
               end else e.serr[b] = 1'b1;
            end
         end
      end
      e.oh  = om;
      e.cnt = '0;
      for (int b = 0; b < BC; b++) e.cnt[b*CW +: CW] = CW'(cm[b]);
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      state_m = !rst;
      g = sb_q.pop_front();
      chk("bitmap_hash", 128'(fold(bus.one_hot)), 128'(fold(g.oh)));
      chk("bitmap_pop", 128'($countones(bus.one_hot)), 128'($countones(g.oh)));
      chk("bin_count", 128'(bus.bin_count), g.cnt);
      chk("set_error", 128'(bus.set_error), 128'(g.serr));
      chk("clr_error", 128'(bus.clr_error), 128'(g.cerr));
      idle();
   endtask

   initial begin
      idle();
      om = '0;
      for (int b = 0; b < BC; b++) cm[b] = 0;
      rst = 1'b1;
      @(posedge clk);
      #1;
      state_m = 1'b0;
      step();
      step();
      rst = 1'b0;
      // INIT cycle: ready still low, request ignored
      set_req(1, 9);
      step();
      chk("init_dropped", 128'(bus.one_hot[9]), 128'(0));
      step();

      // single set and clear
      set_req(3, 11);
      step();
      chk("oh11_set", 128'(bus.one_hot[11]), 128'(1));
      chk("cnt3_set", 128'(bus.bin_count[3*CW +: CW]), 128'(1));
      clr_req(11);
      step();
      chk("oh11_clr", 128'(bus.one_hot[11]), 128'(0));
      chk("cnt3_clr", 128'(bus.bin_count[3*CW +: CW]), 128'(0));

      // parallel sets
      for (int b = 0; b < BC; b++) set_req(b, 8 + b);
      step();
      chk("oh_15_8", 128'(bus.one_hot[15:8]), 128'(8'hFF));

      // error cases
      set_req(2, 5);
      step();
      chk("wrong_bin", 128'(bus.set_error), 128'(8'h04));
      step();
      chk("pulse_end", 128'(bus.set_error), 128'(0));
      set_req(0, 8);
      step();
      chk("dup_set", 128'(bus.set_error[0]), 128'(1));
      clr_req(100);
      step();
      chk("clr_zero", 128'(bus.clr_error), 128'(1));
      chk("cnt4_keep", 128'(bus.bin_count[4*CW +: CW]), 128'(1));

      // same-cycle clear and set
      set_req(5, 21);
      step();
      clr_req(21);
      set_req(5, 21);
      step();
      chk("oh21_keep", 128'(bus.one_hot[21]), 128'(1));
      chk("cnt5_keep", 128'(bus.bin_count[5*CW +: CW]), 128'(2));
      chk("no_err", 128'({bus.set_error, bus.clr_error}), 128'(0));

      // random mixed traffic
      for (int c = 0; c < 300; c++) begin
         for (int b = 0; b < BC; b++) begin
            if ($urandom_range(0, 1) == 1) begin
               if ($urandom_range(0, 3) == 0) set_req(b, int'($urandom_range(0, 255)));
               else set_req(b, int'($urandom_range(0, 31)) * BC + b);
            end
         end
         if ($urandom_range(0, 1) == 1) clr_req(int'($urandom_range(0, 255)));
         step();
      end

      // reset mid-stream, then fill bin 0
      rst = 1'b1;
      set_req(2, 2);
      step();
      rst = 1'b0;
      step();
      chk("rst_pop", 128'($countones(bus.one_hot)), 128'(0));
      for (int i = 0; i < IW / BC; i++) begin
         set_req(0, i * BC);
         step();
      end
      chk("cnt0_full", 128'(bus.bin_count[0 +: CW]), 128'(1024));
      set_req(0, 0);
      step();
      chk("full_err", 128'(bus.set_error[0]), 128'(1));

      rst = 1'b1;
      set_req(1, 9);
      clr_req(0);
      step();
      rst = 1'b0;
      step();
      chk("final_pop", 128'($countones(bus.one_hot)), 128'(0));
      chk("final_cnt", 128'(bus.bin_count), 128'(0));
      chk("lost_req", 128'(bus.one_hot[9]), 128'(0));

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
